// File: rtl/chacha_pkg.sv
// Shared types and widths for the ChaCha stream feeder.
// Optional block statistics are enabled with CHACHA_FEEDER_STATS_EN.
package chacha_pkg;
  localparam int CHACHA_BLK_W  = 512;
  localparam int CHACHA_WORD_W = 32;
  localparam int CHACHA_WORDS  = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;
endpackage

// File: rtl/chacha_word_unpacker.sv
// Holds one 512-bit result block and serializes it as 32-bit
// words over a valid/ready handshake.
module chacha_word_unpacker
  import chacha_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [CHACHA_BLK_W-1:0] blk,
  input  logic [3:0]              nlast,
  input  logic                    last_blk,
  output logic                    out_valid,
  output logic [CHACHA_WORD_W-1:0] out_data,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic                    done
);
  logic [CHACHA_BLK_W-1:0] buf_q;
  logic [3:0]              j_q;
  logic                    active_q;
  logic                    at_end;

  assign at_end    = (j_q == nlast);
  assign out_valid = active_q;
  assign out_data  = buf_q[{j_q, 5'b0} +: CHACHA_WORD_W];
  assign out_last  = active_q && last_blk && at_end;
  assign done      = active_q && out_ready && at_end;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q    <= '0;
      j_q      <= '0;
      active_q <= 1'b0;
    end else if (load) begin
      buf_q    <= blk;
      j_q      <= '0;
      active_q <= 1'b1;
    end else if (active_q && out_ready) begin
      if (at_end) begin
        active_q <= 1'b0;
        j_q      <= '0;
      end else begin
        j_q <= j_q + 4'd1;
      end
    end
  end
endmodule

// File: rtl/chacha_stream_feeder.sv
// Word-serial packer/unpacker around chacha_core with block counter.
// Define CHACHA_FEEDER_STATS_EN to count completed blocks on blk_count.
module chacha_stream_feeder
  import chacha_pkg::*;
#(
  parameter int WORDS_PER_BLK = 16,
  parameter int CTR_W         = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [CTR_W-1:0]        ctr_init,
  input  logic                    in_valid,
  input  logic [CHACHA_WORD_W-1:0] in_data,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [CHACHA_WORD_W-1:0] out_data,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic                    core_init,
  output logic                    core_next,
  output logic [CTR_W-1:0]        core_ctr,
  output logic [CHACHA_BLK_W-1:0] core_data_in,
  input  logic                    core_ready,
  input  logic                    core_valid,
  input  logic [CHACHA_BLK_W-1:0] core_data,
  output logic                    busy,
  output logic [31:0]             blk_count
);
  localparam logic [3:0] LAST_IDX = 4'(WORDS_PER_BLK - 1);

  state_t                  state_q, state_d;
  logic [CTR_W-1:0]        ctr_q;
  logic                    first_q;
  logic [3:0]              idx_q;
  logic [CHACHA_BLK_W-1:0] blk_q;
  logic [3:0]              nlast_q;
  logic                    last_q;
  logic                    load;
  logic                    done;
  logic                    accept;
  logic                    blk_end;

  assign accept       = in_valid && in_ready;
  assign blk_end      = (idx_q == LAST_IDX) || in_last;
  assign core_ctr     = ctr_q;
  assign core_data_in = blk_q;
  assign busy         = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    core_init = 1'b0;
    core_next = 1'b0;
    load      = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_FILL;
      S_FILL: begin
        in_ready = 1'b1;
        if (in_valid && blk_end) state_d = S_ISSUE;
      end
      S_ISSUE: if (core_ready) begin
        core_init = first_q;
        core_next = !first_q;
        state_d   = S_WAIT;
      end
      S_WAIT: if (core_valid) begin
        load    = 1'b1;
        state_d = S_DRAIN;
      end
      S_DRAIN: if (done) state_d = last_q ? S_IDLE : S_FILL;
      default: state_d = S_IDLE;
    endcase
  end

  // blk_q is zeroed on every entry to FILL so short blocks pad with 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctr_q   <= '0;
      first_q <= 1'b0;
      idx_q   <= '0;
      blk_q   <= '0;
      nlast_q <= '0;
      last_q  <= 1'b0;
    end else begin
      if (state_q == S_IDLE && start) begin
        ctr_q   <= ctr_init;
        first_q <= 1'b1;
        idx_q   <= '0;
        blk_q   <= '0;
      end
      if (accept) begin
        blk_q[{idx_q, 5'b0} +: CHACHA_WORD_W] <= in_data;
        idx_q <= idx_q + 4'd1;
        if (blk_end) begin
          nlast_q <= idx_q;
          last_q  <= in_last;
        end
      end
      if (state_q == S_ISSUE && core_ready) first_q <= 1'b0;
      if (state_q == S_DRAIN && done) begin
        ctr_q <= ctr_q + CTR_W'(1);
        idx_q <= '0;
        blk_q <= '0;
      end
    end
  end

  chacha_word_unpacker u_unpack (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .blk      (core_data),
    .nlast    (nlast_q),
    .last_blk (last_q),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .out_ready(out_ready),
    .done     (done)
  );

`ifdef CHACHA_FEEDER_STATS_EN
  logic [31:0] cnt_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  cnt_q <= '0;
    else if (load) cnt_q <= cnt_q + 32'd1;
  end
  assign blk_count = cnt_q;
`else
  assign blk_count = '0;
`endif
endmodule
